// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
// Pong game-state sequencer: one update tick per frame in vertical blanking drives
// paddle/ball physics, scoring and the idle/serve/play/score/over state machine.
// Positions only move on the tick, so each visible frame is drawn from stable values.
module pong_game_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PAD_H        = 64,
  parameter int PAD_W        = 8,
  parameter int PAD_X1       = 16,
  parameter int PAD_X2       = 616,
  parameter int BALL_SZ      = 8,
  parameter int PAD_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       btn_p1_up,
  input  logic       btn_p1_dn,
  input  logic       btn_p2_up,
  input  logic       btn_p2_dn,
  input  logic       btn_start,
  output logic       frame_tick,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad1_y,
  output logic [9:0] pad2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] game_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_SCORE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  // 11-bit versions for comparisons, so sums past 1023 never wrap
  localparam logic [10:0] W_H    = 11'(H_ACTIVE);
  localparam logic [10:0] W_V    = 11'(V_ACTIVE);
  localparam logic [10:0] W_SZ   = 11'(BALL_SZ);
  localparam logic [10:0] W_SPD  = 11'(BALL_SPEED);
  localparam logic [10:0] W_PH   = 11'(PAD_H);
  localparam logic [10:0] W_X1W  = 11'(PAD_X1 + PAD_W);
  localparam logic [10:0] W_X2   = 11'(PAD_X2);
  localparam logic [10:0] W_PSP  = 11'(PAD_SPEED);
  localparam logic [10:0] W_PMAX = 11'(V_ACTIVE - PAD_H);

  // 10-bit values that are loaded into position registers
  localparam logic [9:0] N_SPD  = 10'(BALL_SPEED);
  localparam logic [9:0] N_PSP  = 10'(PAD_SPEED);
  localparam logic [9:0] N_PMAX = 10'(V_ACTIVE - PAD_H);
  localparam logic [9:0] N_YMAX = 10'(V_ACTIVE - BALL_SZ);
  localparam logic [9:0] N_X1W  = 10'(PAD_X1 + PAD_W);
  localparam logic [9:0] N_XR   = 10'(PAD_X2 - BALL_SZ);
  localparam logic [9:0] N_BX0  = 10'(H_ACTIVE / 2 - BALL_SZ / 2);
  localparam logic [9:0] N_BY0  = 10'(V_ACTIVE / 2 - BALL_SZ / 2);
  localparam logic [9:0] N_PY0  = 10'(V_ACTIVE / 2 - PAD_H / 2);
  localparam logic [9:0] N_VACT = 10'(V_ACTIVE);
  localparam logic [3:0] N_WIN  = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] N_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t           state_q, state_d;
  logic             frame_tick_q, frame_tick_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic [9:0]       pad1_y_q, pad1_y_d;
  logic [9:0]       pad2_y_q, pad2_y_d;
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             dx_left_q, dx_left_d;
  logic             dy_up_q, dy_up_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic             start_prev_q, start_prev_d;
  logic             p1_scored_q, p1_scored_d;

  logic             start_edge;
  logic [10:0]      bx, by, p1w, p2w;
  logic [9:0]       pad1_nx, pad2_nx, ball_x_nx, ball_y_nx;
  logic             dx_left_nx, dy_up_nx;
  logic             hit_l, hit_r, miss_l, miss_r;
  logic [3:0]       score1_inc, score2_inc;

  // One paddle step: exactly one button moves it, clamped to the screen
  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] yw;
    yw       = {1'b0, y};
    pad_step = y;
    if (up && !dn) begin
      pad_step = (yw < W_PSP) ? 10'd0 : y - N_PSP;
    end else if (dn && !up) begin
      pad_step = (yw + W_PSP > W_PMAX) ? N_PMAX : y + N_PSP;
    end
  endfunction

  // Candidate physics results, all computed from the current (pre-tick) positions
  always_comb begin
    bx  = {1'b0, ball_x_q};
    by  = {1'b0, ball_y_q};
    p1w = {1'b0, pad1_y_q};
    p2w = {1'b0, pad2_y_q};

    pad1_nx = pad_step(pad1_y_q, btn_p1_up, btn_p1_dn);
    pad2_nx = pad_step(pad2_y_q, btn_p2_up, btn_p2_dn);

    ball_y_nx = ball_y_q;
    dy_up_nx  = dy_up_q;
    if (dy_up_q) begin
      if (by < W_SPD) begin
        ball_y_nx = 10'd0;
        dy_up_nx  = 1'b0;
      end else begin
        ball_y_nx = ball_y_q - N_SPD;
      end
    end else begin
      if (by + W_SZ + W_SPD > W_V) begin
        ball_y_nx = N_YMAX;
        dy_up_nx  = 1'b1;
      end else begin
        ball_y_nx = ball_y_q + N_SPD;
      end
    end

    // bx - speed < edge is rewritten as bx < edge + speed to avoid underflow
    hit_l  = dx_left_q && (bx >= W_X1W) && (bx < W_X1W + W_SPD) &&
             (by + W_SZ > p1w) && (by < p1w + W_PH);
    hit_r  = !dx_left_q && (bx + W_SZ <= W_X2) && (bx + W_SZ + W_SPD > W_X2) &&
             (by + W_SZ > p2w) && (by < p2w + W_PH);
    miss_l = dx_left_q && (bx < W_SPD);
    miss_r = !dx_left_q && (bx + W_SZ + W_SPD > W_H);

    ball_x_nx  = ball_x_q;
    dx_left_nx = dx_left_q;
    if (hit_l) begin
      ball_x_nx  = N_X1W;
      dx_left_nx = 1'b0;
    end else if (hit_r) begin
      ball_x_nx  = N_XR;
      dx_left_nx = 1'b1;
    end else if (dx_left_q) begin
      ball_x_nx = ball_x_q - N_SPD;
    end else begin
      ball_x_nx = ball_x_q + N_SPD;
    end

    score1_inc = (score1_q == N_WIN) ? score1_q : score1_q + 4'd1;
    score2_inc = (score2_q == N_WIN) ? score2_q : score2_q + 4'd1;
  end

  // Next-state logic: physics commits only on the tick; SCORE resolves on the next clock
  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    pad1_y_d     = pad1_y_q;
    pad2_y_d     = pad2_y_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    dx_left_d    = dx_left_q;
    dy_up_d      = dy_up_q;
    serve_cnt_d  = serve_cnt_q;
    p1_scored_d  = p1_scored_q;
    start_prev_d = btn_start;
    frame_tick_d = (vpos == N_VACT) && (hpos == 10'd0);
    start_edge   = btn_start & ~start_prev_q;

    case (state_q)
      // start is a one-cycle edge, so it is honoured on any cycle rather than only on a tick
      ST_IDLE: begin
        ball_x_d  = N_BX0;
        ball_y_d  = N_BY0;
        pad1_y_d  = N_PY0;
        pad2_y_d  = N_PY0;
        dx_left_d = 1'b0;
        dy_up_d   = 1'b0;
        if (start_edge) begin
          state_d     = ST_SERVE;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick_q) begin
          pad1_y_d = pad1_nx;
          pad2_y_d = pad2_nx;
          ball_x_d = N_BX0;
          ball_y_d = N_BY0;
          dy_up_d  = 1'b0;
          if (serve_cnt_q == N_SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick_q) begin
          pad1_y_d = pad1_nx;
          pad2_y_d = pad2_nx;
          // a paddle hit always wins over a miss; on a miss the ball stays where it is
          if (!hit_l && !hit_r && (miss_l || miss_r)) begin
            state_d     = ST_SCORE;
            p1_scored_d = miss_r;
          end else begin
            ball_x_d  = ball_x_nx;
            ball_y_d  = ball_y_nx;
            dx_left_d = dx_left_nx;
            dy_up_d   = dy_up_nx;
          end
        end
      end
      ST_SCORE: begin
        serve_cnt_d = '0;
        // next serve heads toward whoever conceded
        if (p1_scored_q) begin
          score1_d  = score1_inc;
          dx_left_d = 1'b0;
          state_d   = (score1_inc == N_WIN) ? ST_OVER : ST_SERVE;
        end else begin
          score2_d  = score2_inc;
          dx_left_d = 1'b1;
          state_d   = (score2_inc == N_WIN) ? ST_OVER : ST_SERVE;
        end
        if (state_d == ST_SERVE) begin
          ball_x_d = N_BX0;
          ball_y_d = N_BY0;
          dy_up_d  = 1'b0;
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          ball_x_d    = N_BX0;
          ball_y_d    = N_BY0;
          dx_left_d   = 1'b0;
          dy_up_d     = 1'b0;
          serve_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset to the centred idle position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_tick_q <= 1'b0;
      ball_x_q     <= N_BX0;
      ball_y_q     <= N_BY0;
      pad1_y_q     <= N_PY0;
      pad2_y_q     <= N_PY0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      dx_left_q    <= 1'b0;
      dy_up_q      <= 1'b0;
      serve_cnt_q  <= '0;
      start_prev_q <= 1'b0;
      p1_scored_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= frame_tick_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      pad1_y_q     <= pad1_y_d;
      pad2_y_q     <= pad2_y_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      dx_left_q    <= dx_left_d;
      dy_up_q      <= dy_up_d;
      serve_cnt_q  <= serve_cnt_d;
      start_prev_q <= start_prev_d;
      p1_scored_q  <= p1_scored_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign pad1_y     = pad1_y_q;
  assign pad2_y     = pad2_y_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pong_game_ctrl: frame tick timing, serve timing, paddle clamping,
// wall bounce, paddle hit and miss, scoring, game over and restart.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       btn_p1_up, btn_p1_dn, btn_p2_up, btn_p2_dn, btn_start;
  logic       frame_tick;
  logic [9:0] ball_x, ball_y, pad1_y, pad2_y;
  logic [3:0] score1, score2;
  logic [2:0] game_state;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic exp_ft;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .btn_p1_up  (btn_p1_up),
    .btn_p1_dn  (btn_p1_dn),
    .btn_p2_up  (btn_p2_up),
    .btn_p2_dn  (btn_p2_dn),
    .btn_start  (btn_start),
    .frame_tick (frame_tick),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pad1_y     (pad1_y),
    .pad2_y     (pad2_y),
    .score1     (score1),
    .score2     (score2),
    .game_state (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one frame: raster hits (480,0), frame_tick rises next cycle, state updates on the edge after
  task automatic tick();
    @(negedge clk); vpos = 10'd480; hpos = 10'd0;
    @(negedge clk); vpos = 10'd0;   hpos = 10'd1;
    @(negedge clk);
  endtask

  // a frame whose update edge also carries a fresh start press
  task automatic start_tick();
    @(negedge clk); vpos = 10'd480; hpos = 10'd0;
    @(negedge clk); vpos = 10'd0;   hpos = 10'd1; btn_start = 1'b1;
    @(negedge clk); btn_start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  game_state, 0);
    chk({tag, "_tick"},   frame_tick, 0);
    chk({tag, "_ball_x"}, ball_x, 316);
    chk({tag, "_ball_y"}, ball_y, 236);
    chk({tag, "_pad1"},   pad1_y, 208);
    chk({tag, "_pad2"},   pad2_y, 208);
    chk({tag, "_score1"}, score1, 0);
    chk({tag, "_score2"}, score2, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hpos = 10'd1; vpos = 10'd0;
    btn_p1_up = 1'b0; btn_p1_dn = 1'b0; btn_p2_up = 1'b0; btn_p2_dn = 1'b0; btn_start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // raster window around (480,0): exactly one pulse, one cycle after the match
    exp_ft = 1'b0;
    for (int v = 478; v <= 481; v++) begin
      for (int h = 0; h < 4; h++) begin
        @(negedge clk);
        chk("frame_tick_scan", frame_tick, exp_ft);
        pulses += int'(frame_tick);
        vpos = 10'(v); hpos = 10'(h);
        exp_ft = (v == 480) && (h == 0);
      end
    end
    @(negedge clk);
    chk("frame_tick_scan_last", frame_tick, exp_ft);
    pulses += int'(frame_tick);
    chk("frame_tick_count", pulses, 1);
    vpos = 10'd0; hpos = 10'd1;

    // game 1: start, then paddle clamping during the 60 serve frames
    btn_p1_up = 1'b1; btn_p2_dn = 1'b1;
    start_tick();
    chk("start_to_serve", game_state, 1);
    repeat (51) tick();
    chk("pad1_at_4", pad1_y, 4);
    chk("pad2_at_412", pad2_y, 412);
    tick();
    chk("pad1_sat0_a", pad1_y, 0);
    chk("pad2_sat416_a", pad2_y, 416);
    tick();
    chk("pad1_sat0_b", pad1_y, 0);
    chk("pad2_sat416_b", pad2_y, 416);
    btn_p1_up = 1'b0; btn_p1_dn = 1'b1; btn_p2_dn = 1'b0;
    tick();
    chk("pad1_down_4", pad1_y, 4);
    btn_p1_up = 1'b1; btn_p2_up = 1'b1; btn_p2_dn = 1'b1;
    tick();
    chk("pad1_both_hold", pad1_y, 4);
    chk("pad2_both_hold", pad2_y, 416);
    btn_p1_up = 1'b0; btn_p1_dn = 1'b0; btn_p2_up = 1'b0; btn_p2_dn = 1'b0;
    repeat (4) tick();
    chk("serve_59_state", game_state, 1);
    chk("serve_ball_x", ball_x, 316);
    chk("serve_ball_y", ball_y, 236);
    tick();
    chk("serve_60_play", game_state, 2);

    // rally 1: right paddle (at 416) returns, left paddle (at 4) misses
    tick();
    chk("play1_ball_x", ball_x, 318);
    chk("play1_ball_y", ball_y, 238);
    repeat (145) tick();
    chk("r1_x_608", ball_x, 608);
    chk("r1_y_418", ball_y, 418);
    tick();
    chk("r1_hit_r_x", ball_x, 608);
    chk("r1_hit_r_y", ball_y, 416);
    tick();
    chk("r1_after_hit_x", ball_x, 606);
    repeat (206) tick();
    chk("wall_y2", ball_y, 2);
    tick();
    chk("wall_y0", ball_y, 0);
    tick();
    chk("wall_y0_turn", ball_y, 0);
    tick();
    chk("wall_y2_down", ball_y, 2);
    chk("wall_x", ball_x, 188);
    repeat (82) tick();
    chk("r1_x_24", ball_x, 24);
    chk("r1_y_166", ball_y, 166);
    tick();
    chk("r1_no_hit_x", ball_x, 22);
    repeat (11) tick();
    chk("r1_x_0", ball_x, 0);
    tick();
    chk("r1_miss_state", game_state, 3);
    chk("r1_miss_hold_x", ball_x, 0);
    chk("r1_miss_hold_y", ball_y, 190);
    @(negedge clk);
    chk("r1_score2", score2, 1);
    chk("r1_score1", score1, 0);
    chk("r1_reserve", game_state, 1);

    // rally 2: serve toward P1, left paddle driven down to 400 to return the ball
    btn_p1_dn = 1'b1;
    repeat (60) tick();
    chk("r2_play", game_state, 2);
    chk("r2_pad1_244", pad1_y, 244);
    tick();
    chk("r2_dx_left_x", ball_x, 314);
    chk("r2_y", ball_y, 238);
    repeat (38) tick();
    chk("r2_pad1_400", pad1_y, 400);
    btn_p1_dn = 1'b0;
    repeat (107) tick();
    chk("r2_x_24", ball_x, 24);
    chk("r2_y_418", ball_y, 418);
    tick();
    chk("r2_hit_l_x", ball_x, 24);
    chk("r2_hit_l_y", ball_y, 416);
    tick();
    chk("r2_after_hit_x", ball_x, 26);
    chk("r2_after_hit_y", ball_y, 414);

    // asynchronous reset in the middle of play
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b0;

    // game 3: right paddle parked at 0, P1 takes every point until game over
    btn_p2_up = 1'b1;
    start_tick();
    chk("g3_serve", game_state, 1);
    for (int r = 1; r <= 9; r++) begin
      repeat (60) tick();
      chk("g3_play", game_state, 2);
      chk("g3_pad2_top", pad2_y, 0);
      repeat (158) tick();
      chk("g3_x_632", ball_x, 632);
      tick();
      chk("g3_score_state", game_state, 3);
      @(negedge clk);
      chk("g3_score1", score1, 32'(r));
      chk("g3_score2", score2, 0);
      chk("g3_next_state", game_state, (r == 9) ? 32'd4 : 32'd1);
    end
    btn_p1_dn = 1'b1;
    repeat (3) tick();
    chk("over_state", game_state, 4);
    chk("over_ball_x", ball_x, 632);
    chk("over_ball_y", ball_y, 394);
    chk("over_pad1", pad1_y, 208);
    chk("over_score1", score1, 9);
    btn_p1_dn = 1'b0;
    start_tick();
    chk("restart_state", game_state, 1);
    chk("restart_score1", score1, 0);
    chk("restart_score2", score2, 0);
    tick();
    chk("restart_ball_x", ball_x, 316);
    chk("restart_ball_y", ball_y, 236);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
